// File: rtl/nic_vc_flow_core.sv
// NI flow-control core: per-VC input flit FIFOs, round-robin input-VC arbiter,
// and per-output-VC credit counters with candidate output-VC selection.
module nic_vc_flow_core #(
    parameter int VC_NUM_PER_PORT   = 2,
    parameter int PYLD_WIDTH        = 32,
    parameter int FLIT_TYPE_WIDTH   = 2,
    parameter int BUFFER_NUM_PER_VC = 16,
    parameter int CAND_VC_SEL_MODE  = 0,
    parameter int FLIT_WIDTH        = PYLD_WIDTH + FLIT_TYPE_WIDTH + VC_NUM_PER_PORT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [FLIT_WIDTH-1:0]      din,
    input  logic [VC_NUM_PER_PORT-1:0] vc_num_wr,
    input  logic                       wr_en,
    input  logic [VC_NUM_PER_PORT-1:0] vc_num_rd,
    input  logic                       rd_en,
    output logic [FLIT_WIDTH-1:0]      dout,
    output logic [VC_NUM_PER_PORT-1:0] vc_not_empty,
    output logic [VC_NUM_PER_PORT-1:0] vc_nearly_full,
    input  logic [VC_NUM_PER_PORT-1:0] arb_request,
    output logic [VC_NUM_PER_PORT-1:0] arb_grant,
    output logic                       arb_any_grant,
    input  logic [VC_NUM_PER_PORT-1:0] ovc_wr_in,
    input  logic [VC_NUM_PER_PORT-1:0] credit_in,
    input  logic                       cand_wr_vc_en,
    output logic [VC_NUM_PER_PORT-1:0] full_vc,
    output logic [VC_NUM_PER_PORT-1:0] cand_vc
);

    localparam int unsigned V    = VC_NUM_PER_PORT;
    localparam int unsigned VIW  = (V > 1) ? $clog2(V) : 1;
    localparam int unsigned PTRW = $clog2(BUFFER_NUM_PER_VC);
    localparam int unsigned CNTW = PTRW + 1;
    localparam logic [CNTW-1:0] DEPTH     = CNTW'(BUFFER_NUM_PER_VC);
    localparam logic [CNTW-1:0] NEAR_FULL = CNTW'(BUFFER_NUM_PER_VC - 1);

    // First requester at or after ptr, searching cyclically.
    function automatic logic [V-1:0] rr_pick(input logic [V-1:0] req, input logic [VIW-1:0] ptr);
        logic [V-1:0] gnt;
        int unsigned  idx;
        gnt = '0;
        for (int unsigned k = 0; k < V; k++) begin
            idx = (32'(ptr) + k) % V;
            if (gnt == '0 && req[idx]) gnt[idx] = 1'b1;
        end
        return gnt;
    endfunction

    function automatic logic [VIW-1:0] ptr_after(input logic [V-1:0] oh);
        logic [VIW-1:0] nxt;
        nxt = '0;
        for (int unsigned k = 0; k < V; k++)
            if (oh[k]) nxt = VIW'((k + 1) % V);
        return nxt;
    endfunction

    logic [FLIT_WIDTH-1:0] mem_q  [V][BUFFER_NUM_PER_VC];
    logic [PTRW-1:0]       wptr_q [V];
    logic [PTRW-1:0]       rptr_q [V];
    logic [CNTW-1:0]       fcnt_q [V];
    logic [V-1:0]          push, pop;
    logic [FLIT_WIDTH-1:0] dout_q, dout_d;

    always_comb begin
        push           = '0;
        pop            = '0;
        vc_not_empty   = '0;
        vc_nearly_full = '0;
        dout_d         = dout_q;
        for (int unsigned v = 0; v < V; v++) begin
            push[v]           = wr_en && vc_num_wr[v] && (fcnt_q[v] != DEPTH);
            pop[v]            = rd_en && vc_num_rd[v] && (fcnt_q[v] != '0);
            vc_not_empty[v]   = (fcnt_q[v] != '0);
            vc_nearly_full[v] = (fcnt_q[v] >= NEAR_FULL);
            if (pop[v]) dout_d = mem_q[v][rptr_q[v]];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned v = 0; v < V; v++)
            if (push[v]) mem_q[v][wptr_q[v]] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
            for (int unsigned v = 0; v < V; v++) begin
                wptr_q[v] <= '0;
                rptr_q[v] <= '0;
                fcnt_q[v] <= '0;
            end
        end else begin
            dout_q <= dout_d;
            for (int unsigned v = 0; v < V; v++) begin
                if (push[v]) wptr_q[v] <= wptr_q[v] + PTRW'(1);
                if (pop[v])  rptr_q[v] <= rptr_q[v] + PTRW'(1);
                case ({push[v], pop[v]})
                    2'b10:   fcnt_q[v] <= fcnt_q[v] + CNTW'(1);
                    2'b01:   fcnt_q[v] <= fcnt_q[v] - CNTW'(1);
                    default: fcnt_q[v] <= fcnt_q[v];
                endcase
            end
        end
    end

    assign dout = dout_q;

    logic [VIW-1:0] arb_ptr_q, arb_ptr_d;

    always_comb begin
        arb_grant     = rr_pick(arb_request, arb_ptr_q);
        arb_any_grant = |arb_grant;
        arb_ptr_d     = arb_any_grant ? ptr_after(arb_grant) : arb_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) arb_ptr_q <= '0;
        else       arb_ptr_q <= arb_ptr_d;
    end

    logic [CNTW-1:0] cred_q [V];

    always_ff @(posedge clk) begin
        for (int unsigned v = 0; v < V; v++) begin
            if (reset)
                cred_q[v] <= DEPTH;
            else if (ovc_wr_in[v] && !credit_in[v] && cred_q[v] != '0)
                cred_q[v] <= cred_q[v] - CNTW'(1);
            else if (credit_in[v] && !ovc_wr_in[v] && cred_q[v] != DEPTH)
                cred_q[v] <= cred_q[v] + CNTW'(1);
        end
    end

    logic [V-1:0]    cand_q, cand_d, avail, rr_sel, max_sel;
    logic [VIW-1:0]  cand_ptr_q, cand_ptr_d;
    logic [CNTW-1:0] best;

    always_comb begin
        full_vc = '0;
        for (int unsigned v = 0; v < V; v++)
            full_vc[v] = (cred_q[v] == '0);
        avail  = ~full_vc;
        rr_sel = rr_pick(avail, cand_ptr_q);
        // Strict compare while scanning upward keeps the lowest index on ties.
        max_sel = '0;
        best    = '0;
        for (int unsigned v = 0; v < V; v++) begin
            if (avail[v] && (max_sel == '0 || cred_q[v] > best)) begin
                max_sel    = '0;
                max_sel[v] = 1'b1;
                best       = cred_q[v];
            end
        end
        cand_d     = cand_q;
        cand_ptr_d = cand_ptr_q;
        if (cand_wr_vc_en && avail != '0) begin
            if (CAND_VC_SEL_MODE == 0) begin
                cand_d     = rr_sel;
                cand_ptr_d = ptr_after(rr_sel);
            end else begin
                cand_d = max_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q     <= '0;
            cand_ptr_q <= '0;
        end else begin
            cand_q     <= cand_d;
            cand_ptr_q <= cand_ptr_d;
        end
    end

    assign cand_vc = cand_q;

endmodule

// File: tb/tb_nic_vc_flow_core.sv
// Directed bench for nic_vc_flow_core: queue/counter model checked every cycle,
// with literal expectations at the key points of each scenario.
`timescale 1ns/1ps
module tb_nic_vc_flow_core;
    localparam int V  = 2;
    localparam int B  = 16;
    localparam int FW = 32 + 2 + V;

    logic          clk = 1'b0;
    logic          reset, wr_en, rd_en, cand_wr_vc_en;
    logic [FW-1:0] din;
    logic [V-1:0]  vc_num_wr, vc_num_rd, arb_request, ovc_wr_in, credit_in;

    logic [FW-1:0] dout0, dout1;
    logic [V-1:0]  ne0, ne1, nf0, nf1, g0, g1, full0, full1, cand0, cand1;
    logic          any0, any1;

    always #5 clk = ~clk;

    nic_vc_flow_core #(.VC_NUM_PER_PORT(V), .PYLD_WIDTH(32), .FLIT_TYPE_WIDTH(2),
                       .BUFFER_NUM_PER_VC(B), .CAND_VC_SEL_MODE(0)) dut_rr (
        .clk(clk), .reset(reset), .din(din), .vc_num_wr(vc_num_wr), .wr_en(wr_en),
        .vc_num_rd(vc_num_rd), .rd_en(rd_en), .dout(dout0), .vc_not_empty(ne0),
        .vc_nearly_full(nf0), .arb_request(arb_request), .arb_grant(g0), .arb_any_grant(any0),
        .ovc_wr_in(ovc_wr_in), .credit_in(credit_in), .cand_wr_vc_en(cand_wr_vc_en),
        .full_vc(full0), .cand_vc(cand0));

    nic_vc_flow_core #(.VC_NUM_PER_PORT(V), .PYLD_WIDTH(32), .FLIT_TYPE_WIDTH(2),
                       .BUFFER_NUM_PER_VC(B), .CAND_VC_SEL_MODE(1)) dut_max (
        .clk(clk), .reset(reset), .din(din), .vc_num_wr(vc_num_wr), .wr_en(wr_en),
        .vc_num_rd(vc_num_rd), .rd_en(rd_en), .dout(dout1), .vc_not_empty(ne1),
        .vc_nearly_full(nf1), .arb_request(arb_request), .arb_grant(g1), .arb_any_grant(any1),
        .ovc_wr_in(ovc_wr_in), .credit_in(credit_in), .cand_wr_vc_en(cand_wr_vc_en),
        .full_vc(full1), .cand_vc(cand1));

    logic [FW-1:0] mq [V][$];
    logic [FW-1:0] m_dout;
    int            m_cred [V];
    int            m_arb_ptr, m_cptr;
    logic [V-1:0]  m_cand_rr, m_cand_max;
    bit            chk_en = 1'b0;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [V-1:0] m_rr(input logic [V-1:0] req, input int ptr);
        int j;
        for (int k = 0; k < V; k++) begin
            j = (ptr + k) % V;
            if (req[j]) return V'(1 << j);
        end
        return '0;
    endfunction

    function automatic int oh2i(input logic [V-1:0] oh);
        for (int k = 0; k < V; k++)
            if (oh[k]) return k;
        return 0;
    endfunction

    task automatic model_tick();
        logic [V-1:0] avail, g;
        int best, sz;
        if (reset) begin
            for (int v = 0; v < V; v++) begin
                mq[v].delete();
                m_cred[v] = B;
            end
            m_dout = '0; m_arb_ptr = 0; m_cptr = 0; m_cand_rr = '0; m_cand_max = '0;
        end else begin
            for (int v = 0; v < V; v++) avail[v] = (m_cred[v] != 0);
            if (cand_wr_vc_en && avail != '0) begin
                m_cand_rr = m_rr(avail, m_cptr);
                m_cptr    = (oh2i(m_cand_rr) + 1) % V;
                best = -1;
                for (int v = 0; v < V; v++)
                    if (avail[v] && m_cred[v] > best) begin
                        best = m_cred[v];
                        m_cand_max = V'(1 << v);
                    end
            end
            g = m_rr(arb_request, m_arb_ptr);
            if (g != '0) m_arb_ptr = (oh2i(g) + 1) % V;
            for (int v = 0; v < V; v++) begin
                sz = mq[v].size();
                if (rd_en && vc_num_rd[v] && sz > 0) m_dout = mq[v].pop_front();
                if (wr_en && vc_num_wr[v] && sz < B) mq[v].push_back(din);
                if (ovc_wr_in[v] && !credit_in[v] && m_cred[v] > 0) m_cred[v]--;
                else if (credit_in[v] && !ovc_wr_in[v] && m_cred[v] < B) m_cred[v]++;
            end
        end
    endtask

    initial forever begin
        logic [V-1:0] e_ne, e_nf, e_full, e_g;
        @(negedge clk);
        if (chk_en) begin
            for (int v = 0; v < V; v++) begin
                e_ne[v]   = mq[v].size() > 0;
                e_nf[v]   = mq[v].size() >= B - 1;
                e_full[v] = m_cred[v] == 0;
            end
            e_g = m_rr(arb_request, m_arb_ptr);
            check("dout_rr", dout0, m_dout);
            check("dout_max", dout1, m_dout);
            check("not_empty", ne0, e_ne);
            check("nearly_full", nf0, e_nf);
            check("grant", g0, e_g);
            check("any_grant", any0, e_g != '0);
            check("full_vc", full0, e_full);
            check("full_vc_max", full1, e_full);
            check("cand_rr", cand0, m_cand_rr);
            check("cand_max", cand1, m_cand_max);
        end
    end

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic clear_inputs();
        wr_en = 0; rd_en = 0; cand_wr_vc_en = 0; din = '0;
        vc_num_wr = '0; vc_num_rd = '0; arb_request = '0; ovc_wr_in = '0; credit_in = '0;
    endtask

    task automatic push(input logic [V-1:0] vc, input logic [FW-1:0] d);
        wr_en = 1; vc_num_wr = vc; din = d;
        step();
        wr_en = 0; vc_num_wr = '0;
    endtask

    task automatic pop(input logic [V-1:0] vc);
        rd_en = 1; vc_num_rd = vc;
        step();
        rd_en = 0; vc_num_rd = '0;
    endtask

    task automatic credits(input logic [V-1:0] wr, input logic [V-1:0] cr, input int n);
        ovc_wr_in = wr; credit_in = cr;
        for (int i = 0; i < n; i++) step();
        ovc_wr_in = '0; credit_in = '0;
    endtask

    initial begin
        logic [FW-1:0] fa, fb, fc, fx, fy;
        logic [V-1:0]  exp_g [4];
        fa = 36'hA_1111_0001; fb = 36'hB_2222_0002; fc = 36'hC_3333_0003;
        fx = 36'h5_0000_00AA; fy = 36'h6_0000_00BB;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;

        clear_inputs();
        reset = 1;
        step();
        chk_en = 1;
        step();
        reset = 0;
        check("rst_dout", dout0, 0);
        check("rst_not_empty", ne0, 2'b00);
        check("rst_full_vc", full0, 2'b00);
        check("rst_cand_max", cand1, 2'b00);

        // Three flits through VC0
        push(2'b01, fa); push(2'b01, fb); push(2'b01, fc);
        check("abc_not_empty", ne0, 2'b01);
        pop(2'b01); check("pop_a", dout0, fa);
        pop(2'b01); check("pop_b", dout0, fb);
        pop(2'b01); check("pop_c", dout0, fc);
        check("abc_drained", ne0, 2'b00);

        // Write+read on an empty VC: only the write lands
        wr_en = 1; vc_num_wr = 2'b01; din = fx; rd_en = 1; vc_num_rd = 2'b01;
        step();
        check("wr_rd_empty_dout", dout0, fc);
        check("wr_rd_empty_ne", ne0, 2'b01);
        din = fy;
        step();
        clear_inputs();
        check("wr_rd_dout", dout0, fx);
        check("wr_rd_ne", ne0, 2'b01);
        pop(2'b01); check("pop_y", dout0, fy);

        // Fill VC1, overflow write, drain in order
        for (int i = 0; i < B; i++) begin
            push(2'b10, FW'(36'h100 + i));
            if (i == B - 3) check("nf_at_14", nf0, 2'b00);
            if (i == B - 2) check("nf_at_15", nf0, 2'b10);
        end
        push(2'b10, 36'hD_DEAD_BEEF);
        check("full_fifo_nf", nf0, 2'b10);
        for (int i = 0; i < B; i++) begin
            pop(2'b10);
            check("fifo_order", dout0, 36'h100 + i);
        end
        check("vc1_empty", ne0, 2'b00);
        pop(2'b10); check("pop_empty_hold", dout0, 36'h10F);

        // Round-robin arbiter
        arb_request = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1 check("arb_both", g0, exp_g[i]);
            step();
        end
        arb_request = 2'b10;
        #1 check("arb_vc1", g0, 2'b10);
        step();
        arb_request = 2'b00;
        #1 check("arb_none", any0, 1'b0);
        step();

        // Credits: exhaust VC0, simultaneous consume+return, saturation
        credits(2'b10, 2'b10, 1);
        credits(2'b00, 2'b10, 1);
        credits(2'b01, 2'b00, B);
        check("vc0_full", full0, 2'b01);
        credits(2'b01, 2'b01, 1); check("vc0_full_both", full0, 2'b01);
        credits(2'b01, 2'b00, 1); check("vc0_full_sat", full0, 2'b01);
        credits(2'b00, 2'b01, 5);
        credits(2'b10, 2'b00, 7);
        cand_wr_vc_en = 1; step(); cand_wr_vc_en = 0;
        check("cand_max_5_9", cand1, 2'b10);
        check("cand_rr_first", cand0, 2'b01);

        credits(2'b11, 2'b00, 10);
        check("both_full", full0, 2'b11);
        cand_wr_vc_en = 1; step(); cand_wr_vc_en = 0;
        check("cand_max_hold", cand1, 2'b10);
        check("cand_rr_hold", cand0, 2'b01);
        credits(2'b00, 2'b10, 1);
        cand_wr_vc_en = 1; step(); cand_wr_vc_en = 0;
        check("cand_rr_only_vc1", cand0, 2'b10);
        credits(2'b00, 2'b01, 1);
        cand_wr_vc_en = 1; step(); cand_wr_vc_en = 0;
        check("cand_rr_wrap", cand0, 2'b01);
        check("cand_max_tie", cand1, 2'b01);

        // Reset with traffic in flight
        push(2'b01, fa); push(2'b10, fb); push(2'b01, fc);
        pop(2'b01);
        check("pre_rst_dout", dout0, fa);
        reset = 1; step(); reset = 0;
        check("mid_rst_ne", ne0, 2'b00);
        check("mid_rst_dout", dout0, 0);
        check("mid_rst_full", full0, 2'b00);
        check("mid_rst_cand", cand0, 2'b00);
        check("mid_rst_cand_max", cand1, 2'b00);
        credits(2'b10, 2'b00, B - 1); check("cred_15_used", full0, 2'b00);
        credits(2'b10, 2'b00, 1);     check("cred_16_used", full0, 2'b10);
        step();

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
